uart_tx_arb: RTL and testbench

Round-robin scheduler that shares one UART transmitter (trmt/tx_data/tx_done interface) among NUM_REQ requesters. Each requester offers a 16-bit word. The block grants one requester, captures its word, and sequences it out as two bytes (high byte first). It pulses an ack when the last byte completes. It sits between the command/telemetry sources and the single UART transmitter.

---
 rtl/uart_arb_pkg.sv | 16 +
 rtl/uart_tx_arb_rr_arb.sv | 31 +++
 rtl/uart_tx_arb.sv | 120 ++++++++++++
 tb/tb_uart_tx_arb.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_arb_pkg.sv
// uart_arb_pkg: shared types and constants for uart_tx_arb.
// Build option: define UART_ARB_HDR_EN for 3-byte transfers
// (header, high byte, low byte). Leave it undefined for 2-byte transfers.
package uart_arb_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, WAIT, DONE} state_t;

    localparam logic [3:0] HDR_TAG = 4'hA;

`ifdef UART_ARB_HDR_EN
    localparam int BYTES_PER_XFER = 3;
`else
    localparam int BYTES_PER_XFER = 2;
`endif

endpackage

// File: rtl/uart_tx_arb_rr_arb.sv
// rr_arb: combinational round-robin pick, reusable on its own.
// Ports:
//   req      in  NUM_REQ  request vector
//   last_gnt in  ID_W     most recently served index
//   gnt_id   out ID_W     first set req searching upward from last_gnt+1 with wrap
//   any_req  out 1        at least one request is pending
module rr_arb #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    last_gnt,
    output logic [ID_W-1:0]    gnt_id,
    output logic               any_req
);

    logic [ID_W-1:0] idx;

    // Walk from the farthest candidate down to the nearest so the nearest
    // pending requester after last_gnt is the one left in gnt_id.
    always_comb begin
        gnt_id  = '0;
        idx     = '0;
        any_req = |req;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = ID_W'((int'(last_gnt) + k) % NUM_REQ);
            if (req[idx]) gnt_id = idx;
        end
    end

endmodule

// File: rtl/uart_tx_arb.sv
// uart_tx_arb: round-robin scheduler sharing one UART transmitter among NUM_REQ requesters.
// Build option: UART_ARB_HDR_EN prepends a header byte {4'hA, 1'b0, gnt_id[2:0]}.
// Ports:
//   clk      in  1          system clock
//   rst      in  1          synchronous active-high reset
//   req      in  NUM_REQ    level requests, held until ack
//   req_data in  16*NUM_REQ packed words, requester i at [16*i+15:16*i]
//   ack      out NUM_REQ    one-cycle pulse to the granted requester when its word is sent
//   busy     out 1          high whenever not idle
//   gnt_id   out ID_W       current / last granted requester
//   trmt     out 1          one-cycle start pulse to the transmitter
//   tx_data  out 8          byte presented to the transmitter
//   tx_done  in  1          transmitter done level
module uart_tx_arb
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [16*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]    ack,
    output logic                  busy,
    output logic [ID_W-1:0]       gnt_id,
    output logic                  trmt,
    output logic [7:0]            tx_data,
    input  logic                  tx_done
);

    localparam logic [1:0] LAST_IDX = 2'(BYTES_PER_XFER - 1);

    state_t          state_q, state_d;
    logic [ID_W-1:0] gnt_q, gnt_d;
    logic [ID_W-1:0] last_gnt_q, last_gnt_d;
    logic [15:0]     word_q, word_d;
    logic [1:0]      byte_idx_q, byte_idx_d;
    logic [7:0]      tx_data_q, tx_data_d;
    logic            tx_done_q;
    logic [ID_W-1:0] pick;
    logic            any_req;
    logic            done_rise;
    logic [7:0]      nxt_byte;

    rr_arb #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_rr (
        .req      (req),
        .last_gnt (last_gnt_q),
        .gnt_id   (pick),
        .any_req  (any_req)
    );

    // Only a fresh edge counts; a level left high from the previous byte does not.
    assign done_rise = tx_done & ~tx_done_q;

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        last_gnt_d = last_gnt_q;
        word_d     = word_q;
        byte_idx_d = byte_idx_q;
        case (state_q)
            IDLE: if (any_req) begin
                gnt_d      = pick;
                word_d     = req_data[16*pick +: 16];
                byte_idx_d = '0;
                state_d    = LOAD;
            end
            LOAD: state_d = WAIT;
            WAIT: if (done_rise) begin
                if (byte_idx_q == LAST_IDX) state_d = DONE;
                else begin
                    byte_idx_d = byte_idx_q + 2'd1;
                    state_d    = LOAD;
                end
            end
            DONE: begin
                last_gnt_d = gnt_q;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // The byte is latched on entry to LOAD so it is already valid while trmt is high.
`ifdef UART_ARB_HDR_EN
    assign nxt_byte = (byte_idx_d == 2'd0) ? {HDR_TAG, 1'b0, 3'(gnt_d)} :
                      (byte_idx_d == 2'd1) ? word_d[15:8] : word_d[7:0];
`else
    assign nxt_byte = (byte_idx_d == 2'd0) ? word_d[15:8] : word_d[7:0];
`endif
    assign tx_data_d = (state_d == LOAD) ? nxt_byte : tx_data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            last_gnt_q <= ID_W'(NUM_REQ - 1);
            word_q     <= '0;
            byte_idx_q <= '0;
            tx_data_q  <= '0;
            tx_done_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            last_gnt_q <= last_gnt_d;
            word_q     <= word_d;
            byte_idx_q <= byte_idx_d;
            tx_data_q  <= tx_data_d;
            tx_done_q  <= tx_done;
        end
    end

    assign trmt    = (state_q == LOAD);
    assign busy    = (state_q != IDLE);
    assign gnt_id  = gnt_q;
    assign tx_data = tx_data_q;
    assign ack     = (state_q == DONE) ? (NUM_REQ'(1) << gnt_q) : '0;

endmodule

// File: tb/tb_uart_tx_arb.sv
// tb_uart_tx_arb: directed self-checking bench for uart_tx_arb with a hand-driven transmitter.
module tb_uart_tx_arb;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;
`ifdef UART_ARB_HDR_EN
    localparam int NB = 3;
`else
    localparam int NB = 2;
`endif

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NUM_REQ-1:0]    req;
    logic [16*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]    ack;
    logic                  busy;
    logic [ID_W-1:0]       gnt_id;
    logic                  trmt;
    logic [7:0]            tx_data;
    logic                  tx_done;

    int checks   = 0;
    int failures = 0;

    uart_tx_arb #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .req_data (req_data),
        .ack      (ack),
        .busy     (busy),
        .gnt_id   (gnt_id),
        .trmt     (trmt),
        .tx_data  (tx_data),
        .tx_done  (tx_done)
    );

    always #5 clk = ~clk;

    // Transmitted bytes packed oldest-first into the low NB bytes.
    function automatic logic [23:0] exp_word(input logic [15:0] w, input logic [1:0] g);
        return (NB == 3) ? {4'hA, 2'b00, g, w} : {8'h00, w};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_trmt(output logic [7:0] d, output bit to);
        to = 1'b1;
        d  = 8'h00;
        for (int i = 0; i < 50; i++) begin
            if (trmt) begin
                d  = tx_data;
                to = 1'b0;
                break;
            end
            tick();
        end
    endtask

    // Transmitter model: clear done after trmt, then raise it a few cycles later.
    task automatic finish_byte(output logic e);
        tx_done = 1'b0;
        tick();
        e = trmt;
        repeat (2) tick();
        tx_done = 1'b1;
        tick();
    endtask

    task automatic do_word(output logic [23:0] obs, output logic [ID_W-1:0] g,
                           output logic [3:0] a, output logic [3:0] a_next,
                           output logic bz, output logic extra, output bit to);
        logic [7:0] d;
        logic       e;
        bit         t;
        obs = '0; g = '0; extra = 1'b0; to = 1'b0;
        for (int k = 0; k < NB; k++) begin
            wait_trmt(d, t);
            to = to | t;
            if (k == 0) g = gnt_id;
            obs = {obs[15:0], d};
            finish_byte(e);
            extra = extra | e;
        end
        a = ack;
        tick();
        a_next = ack;
        bz = busy;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        req = '0; req_data = '0; tx_done = 1'b0;
        do_reset();
        checks++; if (ack !== 4'b0)     begin failures++; $display("FAIL reset_ack got=%h exp=0", ack); end
        checks++; if (trmt !== 1'b0)    begin failures++; $display("FAIL reset_trmt got=%b exp=0", trmt); end
        checks++; if (tx_data !== 8'h0) begin failures++; $display("FAIL reset_tx_data got=%h exp=00", tx_data); end
        checks++; if (gnt_id !== 2'd0)  begin failures++; $display("FAIL reset_gnt got=%0d exp=0", gnt_id); end
        checks++; if (busy !== 1'b0)    begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    endtask

    task automatic test_single();
        logic [23:0] obs; logic [ID_W-1:0] g; logic [3:0] a, an; logic bz, ex; bit to;
        req_data[15:0] = 16'hBEEF;
        req = 4'b0001;
        do_word(obs, g, a, an, bz, ex, to);
        req = 4'b0000;
        checks++; if (to !== 1'b0)                  begin failures++; $display("FAIL single_timeout got=%b exp=0", to); end
        checks++; if (g !== 2'd0)                   begin failures++; $display("FAIL single_gnt got=%0d exp=0", g); end
        checks++; if (obs !== exp_word(16'hBEEF, 2'd0)) begin failures++; $display("FAIL single_bytes got=%h exp=%h", obs, exp_word(16'hBEEF, 2'd0)); end
        checks++; if (a !== 4'b0001)                begin failures++; $display("FAIL single_ack got=%b exp=0001", a); end
        checks++; if (an !== 4'b0000)               begin failures++; $display("FAIL single_ack_pulse got=%b exp=0000", an); end
        checks++; if (bz !== 1'b0)                  begin failures++; $display("FAIL single_busy_after got=%b exp=0", bz); end
        checks++; if (ex !== 1'b0)                  begin failures++; $display("FAIL single_trmt_width got=%b exp=0", ex); end
    endtask

    task automatic test_round_robin();
        logic [23:0] obs; logic [ID_W-1:0] g; logic [3:0] a, an; logic bz, ex; bit to;
        int exp_g [4] = '{1, 3, 1, 3};
        logic [15:0] w;
        do_reset();
        req_data[31:16] = 16'h1111;
        req_data[63:48] = 16'h3333;
        req = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            do_word(obs, g, a, an, bz, ex, to);
            w = (exp_g[i] == 1) ? 16'h1111 : 16'h3333;
            checks++; if (to !== 1'b0) begin failures++; $display("FAIL rr_timeout[%0d] got=%b exp=0", i, to); end
            checks++; if (g !== 2'(exp_g[i])) begin failures++; $display("FAIL rr_gnt[%0d] got=%0d exp=%0d", i, g, exp_g[i]); end
            checks++; if (obs !== exp_word(w, 2'(exp_g[i]))) begin failures++; $display("FAIL rr_bytes[%0d] got=%h exp=%h", i, obs, exp_word(w, 2'(exp_g[i]))); end
            checks++; if (a !== (4'b0001 << exp_g[i])) begin failures++; $display("FAIL rr_ack[%0d] got=%b exp=%b", i, a, 4'b0001 << exp_g[i]); end
            checks++; if (an !== 4'b0000) begin failures++; $display("FAIL rr_ack_pulse[%0d] got=%b exp=0000", i, an); end
        end
        req = 4'b0000;
        tick();
    endtask

    task automatic test_wrap();
        logic [23:0] obs; logic [ID_W-1:0] g; logic [3:0] a, an; logic bz, ex; bit to;
        req_data[15:0]  = 16'hAAAA;
        req_data[47:32] = 16'hCCCC;
        req = 4'b0101;
        do_word(obs, g, a, an, bz, ex, to);
        checks++; if (g !== 2'd0)      begin failures++; $display("FAIL wrap_first_gnt got=%0d exp=0", g); end
        checks++; if (a !== 4'b0001)   begin failures++; $display("FAIL wrap_first_ack got=%b exp=0001", a); end
        req = 4'b0100;
        do_word(obs, g, a, an, bz, ex, to);
        req = 4'b0000;
        checks++; if (g !== 2'd2)      begin failures++; $display("FAIL wrap_second_gnt got=%0d exp=2", g); end
        checks++; if (obs !== exp_word(16'hCCCC, 2'd2)) begin failures++; $display("FAIL wrap_second_bytes got=%h exp=%h", obs, exp_word(16'hCCCC, 2'd2)); end
        checks++; if (a !== 4'b0100)   begin failures++; $display("FAIL wrap_second_ack got=%b exp=0100", a); end
    endtask

    task automatic test_data_change();
        logic [23:0] obs; logic [7:0] d; logic e; bit t, to;
        obs = '0; to = 1'b0;
        req_data[31:16] = 16'h1234;
        req = 4'b0010;
        for (int k = 0; k < NB; k++) begin
            wait_trmt(d, t);
            to = to | t;
            obs = {obs[15:0], d};
            if (k == 0) begin
                req_data[31:16] = 16'h5678;
                req = 4'b0000;
            end
            finish_byte(e);
        end
        checks++; if (to !== 1'b0) begin failures++; $display("FAIL chg_timeout got=%b exp=0", to); end
        checks++; if (obs !== exp_word(16'h1234, 2'd1)) begin failures++; $display("FAIL chg_bytes got=%h exp=%h", obs, exp_word(16'h1234, 2'd1)); end
        checks++; if (ack !== 4'b0010) begin failures++; $display("FAIL chg_ack_after_drop got=%b exp=0010", ack); end
        tick();
    endtask

    task automatic test_stale_done();
        logic [23:0] ew; logic [7:0] d; logic e; bit t; int cnt;
        ew = exp_word(16'h5A3C, 2'd0);
        req_data[15:0] = 16'h5A3C;
        tx_done = 1'b1;
        req = 4'b0001;
        wait_trmt(d, t);
        req = 4'b0000;
        checks++; if (t !== 1'b0 || d !== ew[8*(NB-1) +: 8]) begin failures++; $display("FAIL stale_byte0 got=%h exp=%h", d, ew[8*(NB-1) +: 8]); end
        cnt = 0;
        repeat (4) begin
            tick();
            cnt += int'(trmt);
        end
        checks++; if (cnt !== 0)    begin failures++; $display("FAIL stale_no_advance got=%0d exp=0", cnt); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL stale_busy got=%b exp=1", busy); end
        tx_done = 1'b0;
        repeat (2) tick();
        tx_done = 1'b1;
        tick();
        checks++; if (trmt !== 1'b1 || tx_data !== ew[8*(NB-2) +: 8]) begin failures++; $display("FAIL stale_byte1 got=%b/%h exp=1/%h", trmt, tx_data, ew[8*(NB-2) +: 8]); end
        for (int k = 2; k < NB; k++) begin
            finish_byte(e);
            wait_trmt(d, t);
        end
        finish_byte(e);
        checks++; if (ack !== 4'b0001) begin failures++; $display("FAIL stale_ack got=%b exp=0001", ack); end
        tick();
    endtask

    task automatic test_reset_mid();
        logic [23:0] ew, obs; logic [ID_W-1:0] g; logic [3:0] a, an; logic [7:0] d; logic bz, ex, e; bit t;
        ew = exp_word(16'hCAFE, 2'd2);
        req_data[47:32] = 16'hCAFE;
        req_data[15:0]  = 16'h0F0F;
        req = 4'b0100;
        wait_trmt(d, t);
        checks++; if (gnt_id !== 2'd2 || d !== ew[8*(NB-1) +: 8]) begin failures++; $display("FAIL mid_first got=%0d/%h exp=2/%h", gnt_id, d, ew[8*(NB-1) +: 8]); end
        for (int k = 1; k < NB; k++) begin
            finish_byte(e);
            wait_trmt(d, t);
        end
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (busy !== 1'b0)    begin failures++; $display("FAIL mid_busy got=%b exp=0", busy); end
        checks++; if (trmt !== 1'b0)    begin failures++; $display("FAIL mid_trmt got=%b exp=0", trmt); end
        checks++; if (ack !== 4'b0000)  begin failures++; $display("FAIL mid_ack got=%b exp=0000", ack); end
        req = 4'b0101;
        do_word(obs, g, a, an, bz, ex, t);
        checks++; if (g !== 2'd0)       begin failures++; $display("FAIL mid_regrant_gnt got=%0d exp=0", g); end
        checks++; if (obs !== exp_word(16'h0F0F, 2'd0)) begin failures++; $display("FAIL mid_regrant_bytes got=%h exp=%h", obs, exp_word(16'h0F0F, 2'd0)); end
        checks++; if (a !== 4'b0001)    begin failures++; $display("FAIL mid_regrant_ack got=%b exp=0001", a); end
        req = 4'b0100;
        do_word(obs, g, a, an, bz, ex, t);
        req = 4'b0000;
        checks++; if (g !== 2'd2)       begin failures++; $display("FAIL mid_retry_gnt got=%0d exp=2", g); end
        checks++; if (obs !== ew)       begin failures++; $display("FAIL mid_retry_bytes got=%h exp=%h", obs, ew); end
        checks++; if (a !== 4'b0100)    begin failures++; $display("FAIL mid_retry_ack got=%b exp=0100", a); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_wrap();
        test_data_change();
        test_stale_done();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
